// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the register file write port with a pending-write scoreboard.
// Optional macro REGFILE_WB_SAME_CYCLE_CLEAR_EN: hazard outputs treat the register written this cycle as free.
module regfile_wb_arbiter #(
    parameter int XLEN     = 32,
    parameter int REG_BITS = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_issue_valid,
    input  logic [REG_BITS-1:0] in_issue_reg,
    output logic                out_issue_ready,
    input  logic [REG_BITS-1:0] in_rs1_number,
    input  logic [REG_BITS-1:0] in_rs2_number,
    output logic                out_rs1_busy,
    output logic                out_rs2_busy,
    input  logic                in_a_valid,
    input  logic [REG_BITS-1:0] in_a_number,
    input  logic [XLEN-1:0]     in_a_value,
    input  logic                in_b_valid,
    input  logic [REG_BITS-1:0] in_b_number,
    input  logic [XLEN-1:0]     in_b_value,
    output logic                out_a_ready,
    output logic                out_b_ready,
    output logic                out_write_enable,
    output logic [REG_BITS-1:0] out_write_number,
    output logic [XLEN-1:0]     out_write_value
);

    localparam int NREG = 1 << REG_BITS;

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;
    logic [NREG-1:0] pending;
    logic            last_grant;
    logic            grant_a;
    logic            grant_b;
    logic            set_en;

    // last_grant = 1 means B went last, so A wins a tie
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!rst) begin
            if (in_a_valid && in_b_valid) begin
                grant_a = last_grant;
                grant_b = !last_grant;
            end else begin
                grant_a = in_a_valid;
                grant_b = in_b_valid;
            end
        end
    end

    assign out_a_ready = grant_a;
    assign out_b_ready = grant_b;

    always_comb begin
        out_write_enable = 1'b0;
        out_write_number = '0;
        out_write_value  = '0;
        unique case (1'b1)
            grant_a: begin
                out_write_enable = 1'b1;
                out_write_number = in_a_number;
                out_write_value  = in_a_value;
            end
            grant_b: begin
                out_write_enable = 1'b1;
                out_write_number = in_b_number;
                out_write_value  = in_b_value;
            end
            default: ;
        endcase
    end

    always_comb begin
        pending = busy;
`ifdef REGFILE_WB_SAME_CYCLE_CLEAR_EN
        if (out_write_enable) pending[out_write_number] = 1'b0;
`endif
    end

    assign out_issue_ready = !rst && !pending[in_issue_reg];
    assign out_rs1_busy    = !rst && pending[in_rs1_number];
    assign out_rs2_busy    = !rst && pending[in_rs2_number];

    assign set_en = in_issue_valid && out_issue_ready
                    && (in_issue_reg != '0);

    // set is applied after clear so an issue wins over a same-cycle writeback
    always_comb begin
        busy_next = busy;
        if (out_write_enable) busy_next[out_write_number] = 1'b0;
        if (set_en) busy_next[in_issue_reg] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= '0;
            last_grant <= 1'b0;
        end else begin
            busy <= busy_next;
            if (grant_b)      last_grant <= 1'b1;
            else if (grant_a) last_grant <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: behavioural scoreboard/arbiter model, directed scenarios, then random traffic.
module tb_regfile_wb_arbiter;

    localparam int XLEN = 32;
    localparam int RB   = 5;
    localparam int NR   = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_issue_valid;
    logic [RB-1:0]   in_issue_reg;
    logic            out_issue_ready;
    logic [RB-1:0]   in_rs1_number;
    logic [RB-1:0]   in_rs2_number;
    logic            out_rs1_busy;
    logic            out_rs2_busy;
    logic            in_a_valid;
    logic [RB-1:0]   in_a_number;
    logic [XLEN-1:0] in_a_value;
    logic            in_b_valid;
    logic [RB-1:0]   in_b_number;
    logic [XLEN-1:0] in_b_value;
    logic            out_a_ready;
    logic            out_b_ready;
    logic            out_write_enable;
    logic [RB-1:0]   out_write_number;
    logic [XLEN-1:0] out_write_value;

    regfile_wb_arbiter #(.XLEN(XLEN), .REG_BITS(RB)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_issue_valid   (in_issue_valid),
        .in_issue_reg     (in_issue_reg),
        .out_issue_ready  (out_issue_ready),
        .in_rs1_number    (in_rs1_number),
        .in_rs2_number    (in_rs2_number),
        .out_rs1_busy     (out_rs1_busy),
        .out_rs2_busy     (out_rs2_busy),
        .in_a_valid       (in_a_valid),
        .in_a_number      (in_a_number),
        .in_a_value       (in_a_value),
        .in_b_valid       (in_b_valid),
        .in_b_number      (in_b_number),
        .in_b_value       (in_b_value),
        .out_a_ready      (out_a_ready),
        .out_b_ready      (out_b_ready),
        .out_write_enable (out_write_enable),
        .out_write_number (out_write_number),
        .out_write_value  (out_write_value)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    bit busy_m [NR];
    bit last_b;

`ifdef REGFILE_WB_SAME_CYCLE_CLEAR_EN
    localparam bit SAME = 1'b1;
`else
    localparam bit SAME = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h @%0t", name, got, exp, $time);
        end
    endtask

    task automatic idle();
        rst            = 1'b0;
        in_issue_valid = 1'b0;
        in_issue_reg   = '0;
        in_rs1_number  = '0;
        in_rs2_number  = '0;
        in_a_valid     = 1'b0;
        in_a_number    = '0;
        in_a_value     = '0;
        in_b_valid     = 1'b0;
        in_b_number    = '0;
        in_b_value     = '0;
    endtask

    task automatic start_cycle();
        @(negedge clk);
        idle();
    endtask

    // Compare point: settle after the inputs, compare everything, advance the model.
    task automatic check_cycle();
        bit ga, gb, we, ir, b1, b2;
        int num;
        logic [31:0] val;
        bit pend [NR];
        #1;
        ga = 0; gb = 0;
        if (!rst) begin
            if (in_a_valid && in_b_valid) begin
                if (last_b) ga = 1; else gb = 1;
            end else begin
                ga = in_a_valid;
                gb = in_b_valid;
            end
        end
        we  = ga || gb;
        num = ga ? int'(in_a_number) : gb ? int'(in_b_number) : 0;
        val = ga ? in_a_value : gb ? in_b_value : 32'h0;
        for (int r = 0; r < NR; r++) pend[r] = (r != 0) && busy_m[r];
        if (SAME && we) pend[num] = 0;
        ir = !rst && !pend[in_issue_reg];
        b1 = !rst && pend[in_rs1_number];
        b2 = !rst && pend[in_rs2_number];

        chk("a_ready", 32'(out_a_ready), 32'(ga));
        chk("b_ready", 32'(out_b_ready), 32'(gb));
        chk("write_enable", 32'(out_write_enable), 32'(we));
        chk("write_number", 32'(out_write_number), 32'(num));
        chk("write_value", out_write_value, val);
        chk("issue_ready", 32'(out_issue_ready), 32'(ir));
        chk("rs1_busy", 32'(out_rs1_busy), 32'(b1));
        chk("rs2_busy", 32'(out_rs2_busy), 32'(b2));

        if (rst) begin
            for (int r = 0; r < NR; r++) busy_m[r] = 0;
            last_b = 0;
        end else begin
            if (we) busy_m[num] = 0;
            if (in_issue_valid && ir && in_issue_reg != 0)
                busy_m[in_issue_reg] = 1;
            if (gb) last_b = 1;
            else if (ga) last_b = 0;
        end
    endtask

    initial begin
        for (int r = 0; r < NR; r++) busy_m[r] = 0;
        last_b = 0;
        idle();
        rst = 1'b1;
        #1;
        check_cycle();

        // reset with offers pending: nothing granted
        start_cycle();
        rst = 1; in_a_valid = 1; in_b_valid = 1;
        in_a_number = 1; in_b_number = 2;
        check_cycle();
        chk("rst_a_ready", 32'(out_a_ready), 0);
        chk("rst_we", 32'(out_write_enable), 0);

        // issue x5
        start_cycle();
        in_issue_valid = 1; in_issue_reg = 5; in_rs1_number = 5;
        check_cycle();
        chk("x5_issue_ready", 32'(out_issue_ready), 1);
        chk("x5_rs1_busy0", 32'(out_rs1_busy), 0);
        start_cycle();
        in_issue_valid = 1; in_issue_reg = 5; in_rs1_number = 5;
        check_cycle();
        chk("x5_waw_blocked", 32'(out_issue_ready), 0);
        chk("x5_rs1_busy1", 32'(out_rs1_busy), 1);

        // alternating grants from reset: B, A, B, A
        for (int i = 0; i < 4; i++) begin
            start_cycle();
            in_a_valid = 1; in_a_number = 1; in_a_value = 32'h100 + i;
            in_b_valid = 1; in_b_number = 2; in_b_value = 32'h200 + i;
            check_cycle();
            chk("rr_b_ready", 32'(out_b_ready), (i % 2 == 0) ? 1 : 0);
            chk("rr_a_ready", 32'(out_a_ready), (i % 2 == 0) ? 0 : 1);
            chk("rr_we", 32'(out_write_enable), 1);
        end

        // busy x7 then A writes x7
        start_cycle();
        in_issue_valid = 1; in_issue_reg = 7;
        check_cycle();
        start_cycle();
        in_rs2_number = 7;
        in_a_valid = 1; in_a_number = 7; in_a_value = 32'hDEADBEEF;
        check_cycle();
        chk("x7_write_value", out_write_value, 32'hDEADBEEF);
        chk("x7_rs2_busy_wcycle", 32'(out_rs2_busy), SAME ? 0 : 1);
        start_cycle();
        in_rs2_number = 7;
        check_cycle();
        chk("x7_rs2_busy_after", 32'(out_rs2_busy), 0);

        // issue x9 while B writes x9: set wins
        start_cycle();
        in_issue_valid = 1; in_issue_reg = 9;
        in_b_valid = 1; in_b_number = 9; in_b_value = 32'h99;
        check_cycle();
        start_cycle();
        in_rs1_number = 9;
        check_cycle();
        chk("x9_set_wins", 32'(out_rs1_busy), 1);

        // x0 issue and writeback
        start_cycle();
        in_issue_valid = 1; in_issue_reg = 0; in_rs1_number = 0;
        in_a_valid = 1; in_a_number = 0; in_a_value = 32'h55;
        check_cycle();
        chk("x0_issue_ready", 32'(out_issue_ready), 1);
        chk("x0_we", 32'(out_write_enable), 1);
        chk("x0_num", 32'(out_write_number), 0);
        start_cycle();
        in_rs1_number = 0;
        check_cycle();
        chk("x0_never_busy", 32'(out_rs1_busy), 0);

        // busy x3/x4, then reset with both sources valid
        start_cycle();
        in_issue_valid = 1; in_issue_reg = 3;
        check_cycle();
        start_cycle();
        in_issue_valid = 1; in_issue_reg = 4;
        in_a_valid = 1; in_a_number = 1;
        check_cycle();
        start_cycle();
        rst = 1; in_rs1_number = 3; in_rs2_number = 4;
        in_a_valid = 1; in_a_number = 3; in_b_valid = 1; in_b_number = 4;
        check_cycle();
        chk("mid_rst_a_ready", 32'(out_a_ready), 0);
        chk("mid_rst_b_ready", 32'(out_b_ready), 0);
        start_cycle();
        in_rs1_number = 3; in_rs2_number = 4;
        in_a_valid = 1; in_a_number = 3; in_b_valid = 1; in_b_number = 4;
        check_cycle();
        chk("post_rst_x3", 32'(out_rs1_busy), 0);
        chk("post_rst_x4", 32'(out_rs2_busy), 0);
        chk("post_rst_b_first", 32'(out_b_ready), 1);

        // random traffic over a small register window to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            start_cycle();
            rst            = ($urandom_range(0, 199) == 0);
            in_issue_valid = $urandom_range(0, 1);
            in_issue_reg   = RB'($urandom_range(0, 7));
            in_rs1_number  = RB'($urandom_range(0, 7));
            in_rs2_number  = RB'($urandom_range(0, 7));
            in_a_valid     = ($urandom_range(0, 3) != 0);
            in_a_number    = RB'($urandom_range(0, 7));
            in_a_value     = $urandom;
            in_b_valid     = ($urandom_range(0, 3) != 0);
            in_b_number    = RB'($urandom_range(0, 7));
            in_b_value     = $urandom;
            check_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
